simd_acc_writeback: RTL and testbench

//  Accumulator/write-back stage at the output end of the 32-bit SIMD three-input ALU.
//  - Registers the ALU sum and feeds it back as the W operand.
//  - Consumes the ALU's per-segment carry-outs:
//    - returns them, registered, as the ALU's result_SIMD carry-in;
//    - counts them into per-lane guard bits.
//  - After ACC_LEN samples, presents the packed result plus guard bits downstream on a valid/ready handshake.

---
 rtl/simd_acc_writeback.sv | 148 ++++++++++++++
 tb/tb_simd_acc_writeback.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/simd_acc_writeback.sv
// Accumulator / write-back stage behind the 32-bit SIMD three-input ALU: feeds back S and top-of-lane carries,
// counts lane carries into guard bits, and hands the result downstream. Optional sticky overflow: SIMD_ACC_STICKY_OVF_EN.
module simd_acc_writeback #(
  parameter int WIDTH = 32,
  parameter int GUARD = 4,
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         use_simd,
  input  logic               start,
  input  logic [LEN_W-1:0]   acc_len,
  input  logic [WIDTH-1:0]   alu_s,
  input  logic [3:0]         alu_cout,
  input  logic               alu_valid,
  output logic [WIDTH-1:0]   fb_w,
  output logic [3:0]         fb_cin,
  output logic [WIDTH-1:0]   res_data,
  output logic [4*GUARD-1:0] res_ext,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               busy,
  output logic [1:0]         dbg_state
`ifdef SIMD_ACC_STICKY_OVF_EN
  ,
  output logic [3:0]         res_ovf
`endif
);

  // Result handshake: res_valid is high for the whole DRAIN state and res_data/res_ext are frozen
  // until the cycle where res_valid && res_ready, which is the only cycle the result is consumed.
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DRAIN = 2'd2} state_t;

  state_t             state, next_state;
  logic [1:0]         simd_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt;
  logic [WIDTH-1:0]   acc;
  logic [3:0]         cin_q;
  logic [4*GUARD-1:0] guard, guard_nxt;
  logic [3:0]         top_mask;
  logic [3:0]         wrap;
  logic               accept_start;
  logic               take_sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state   = state;
    accept_start = 1'b0;
    take_sample  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          next_state   = (acc_len == '0) ? DRAIN : ACCUM;
        end
      end
      ACCUM: begin
        if (alu_valid) begin
          take_sample = 1'b1;
          if (cnt == len_q - LEN_W'(1)) next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (res_ready) begin
          if (start) begin
            accept_start = 1'b1;
            next_state   = (acc_len == '0) ? DRAIN : ACCUM;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Segments that terminate a lane; only their carries leave the ALU.
  always_comb begin
    case (simd_q)
      2'b00:   top_mask = 4'b1000;
      2'b01:   top_mask = 4'b1010;
      default: top_mask = 4'b1111;
    endcase
  end

  always_comb begin
    guard_nxt = guard;
    wrap      = '0;
    for (int i = 0; i < 4; i++) begin
      if (alu_cout[i] && top_mask[i]) begin
        guard_nxt[GUARD*i +: GUARD] = guard[GUARD*i +: GUARD] + GUARD'(1);
        wrap[i] = (guard[GUARD*i +: GUARD] == {GUARD{1'b1}});
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      simd_q <= '0;
      len_q  <= '0;
      cnt    <= '0;
      acc    <= '0;
      cin_q  <= '0;
      guard  <= '0;
    end else if (accept_start) begin
      simd_q <= use_simd;
      len_q  <= acc_len;
      cnt    <= '0;
      acc    <= '0;
      cin_q  <= '0;
      guard  <= '0;
    end else if (take_sample) begin
      acc   <= alu_s;
      cin_q <= alu_cout & top_mask;
      guard <= guard_nxt;
      cnt   <= cnt + LEN_W'(1);
    end
  end

`ifdef SIMD_ACC_STICKY_OVF_EN
  logic [3:0] ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            ovf_q <= '0;
    else if (accept_start) ovf_q <= '0;
    else if (take_sample)  ovf_q <= ovf_q | wrap;
  end

  assign res_ovf = ovf_q;
`else
  logic unused_wrap;
  assign unused_wrap = ^wrap;
`endif

  assign fb_w      = acc;
  assign fb_cin    = cin_q;
  assign res_data  = acc;
  assign res_ext   = guard;
  assign res_valid = (state == DRAIN);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_simd_acc_writeback.sv
// Directed bench for simd_acc_writeback; define SIMD_ACC_STICKY_OVF_EN to also exercise res_ovf.
module tb_simd_acc_writeback;

  logic        clk;
  logic        rst_n;
  logic [1:0]  use_simd;
  logic        start;
  logic [7:0]  acc_len;
  logic [31:0] alu_s;
  logic [3:0]  alu_cout;
  logic        alu_valid;
  logic [31:0] fb_w;
  logic [3:0]  fb_cin;
  logic [31:0] res_data;
  logic [15:0] res_ext;
  logic        res_valid;
  logic        res_ready;
  logic        busy;
  logic [1:0]  dbg_state;
`ifdef SIMD_ACC_STICKY_OVF_EN
  logic [3:0]  res_ovf;
`endif

  int checks = 0;
  int errors = 0;

  simd_acc_writeback dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .use_simd  (use_simd),
    .start     (start),
    .acc_len   (acc_len),
    .alu_s     (alu_s),
    .alu_cout  (alu_cout),
    .alu_valid (alu_valid),
    .fb_w      (fb_w),
    .fb_cin    (fb_cin),
    .res_data  (res_data),
    .res_ext   (res_ext),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .dbg_state (dbg_state)
`ifdef SIMD_ACC_STICKY_OVF_EN
    ,
    .res_ovf   (res_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input logic [31:0] s, input logic [3:0] c);
    alu_valid = 1'b1;
    alu_s     = s;
    alu_cout  = c;
    tick();
    alu_valid = 1'b0;
  endtask

  task automatic begin_run(input logic [1:0] mode, input logic [7:0] len);
    use_simd = mode;
    acc_len  = len;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; use_simd = '0; start = 1'b0; acc_len = '0;
    alu_s = '0; alu_cout = '0; alu_valid = 1'b0; res_ready = 1'b0;
    tick(); tick();
    check("rst_fb_w", fb_w, 32'h0);
    check("rst_fb_cin", {28'h0, fb_cin}, 32'h0);
    check("rst_res_ext", {16'h0, res_ext}, 32'h0);
    check("rst_valid_busy", {30'h0, res_valid, busy}, 32'h0);
    rst_n = 1'b1;
    tick();

    // T1: 1x32, three samples with a stall in the middle
    begin_run(2'b00, 8'd3);
    check("t1_busy", {31'h0, busy}, 32'h1);
    check("t1_state_accum", {30'h0, dbg_state}, 32'h1);
    sample(32'd10, 4'b0000);
    check("t1_fb_w_1", fb_w, 32'd10);
    tick();
    check("t1_fb_w_stall", fb_w, 32'd10);
    sample(32'd20, 4'b0000);
    check("t1_valid_early", {31'h0, res_valid}, 32'h0);
    sample(32'd30, 4'b0000);
    check("t1_valid", {31'h0, res_valid}, 32'h1);
    check("t1_res_data", res_data, 32'd30);
    check("t1_res_ext", {16'h0, res_ext}, 32'h0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("t1_busy_after", {31'h0, busy}, 32'h0);
    check("t1_hold_idle", res_data, 32'd30);

    // T2: 4x8, every lane carries twice
    begin_run(2'b10, 8'd2);
    sample(32'd5, 4'b1111);
    check("t2_fb_cin", {28'h0, fb_cin}, 32'hF);
    check("t2_ext_1", {16'h0, res_ext}, 32'h1111);
    sample(32'd7, 4'b1111);
    check("t2_valid", {31'h0, res_valid}, 32'h1);
    check("t2_ext_2", {16'h0, res_ext}, 32'h2222);
    check("t2_res_data", res_data, 32'd7);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // T5: alu_valid ignored in IDLE and DRAIN, zero-length run
    sample(32'hDEAD, 4'b1111);
    check("t5_idle_ignore", res_data, 32'd7);
    begin_run(2'b10, 8'd0);
    check("t5_drain", {30'h0, dbg_state}, 32'h2);
    check("t5_res_data", res_data, 32'h0);
    check("t5_res_ext", {16'h0, res_ext}, 32'h0);
    sample(32'hBEEF, 4'b1111);
    check("t5_drain_ignore", res_data, 32'h0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // T3: 2x16, only non-top carries asserted
    begin_run(2'b01, 8'd5);
    for (int i = 1; i <= 5; i++) begin
      sample(32'(i), 4'b0101);
      check("t3_fb_cin", {28'h0, fb_cin}, 32'h0);
    end
    check("t3_valid", {31'h0, res_valid}, 32'h1);
    check("t3_res_ext", {16'h0, res_ext}, 32'h0);
    check("t3_res_data", res_data, 32'd5);

    // T4: stalled drain ignores start, then back-to-back restart
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1;
      alu_s = 32'h1234_0000 + 32'(i);
      tick();
      check("t4_stable", res_data, 32'd5);
      check("t4_valid_held", {31'h0, res_valid}, 32'h1);
    end
    alu_valid = 1'b0;
    use_simd = 2'b01;
    acc_len = 8'd1;
    res_ready = 1'b1;
    tick();
    start = 1'b0;
    res_ready = 1'b0;
    check("t4_restart_state", {30'h0, dbg_state}, 32'h1);
    check("t4_restart_cleared", res_data, 32'h0);
    sample(32'h55, 4'b1111);
    check("t4_fb_cin_mode01", {28'h0, fb_cin}, 32'hA);
    check("t4_ext_mode01", {16'h0, res_ext}, 32'h1010);
    check("t4_valid", {31'h0, res_valid}, 32'h1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // T6: 1x32 top carry, then reset mid-run
    begin_run(2'b00, 8'd5);
    sample(32'd100, 4'b1111);
    check("t6_fb_cin_mode00", {28'h0, fb_cin}, 32'h8);
    sample(32'd200, 4'b1111);
    check("t6_ext", {16'h0, res_ext}, 32'h2000);
    rst_n = 1'b0;
    #2;
    check("t6_async_fb_w", fb_w, 32'h0);
    check("t6_async_ext", {16'h0, res_ext}, 32'h0);
    check("t6_async_flags", {28'h0, fb_cin}, 32'h0);
    check("t6_async_busy", {31'h0, busy}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef SIMD_ACC_STICKY_OVF_EN
    begin_run(2'b10, 8'd17);
    for (int i = 0; i < 16; i++) sample(32'(i), 4'b1000);
    check("ovf_wrap_guard", {16'h0, res_ext}, 32'h0000);
    check("ovf_set", {28'h0, res_ovf}, 32'h8);
    sample(32'd99, 4'b1000);
    check("ovf_guard_1", {16'h0, res_ext}, 32'h1000);
    check("ovf_sticky", {28'h0, res_ovf}, 32'h8);
    use_simd = 2'b10;
    acc_len = 8'd1;
    start = 1'b1;
    res_ready = 1'b1;
    tick();
    start = 1'b0;
    res_ready = 1'b0;
    check("ovf_cleared", {28'h0, res_ovf}, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
